// File: rtl/masked_sbox_seq_if.sv
// masked_sbox_seq_if: block-level request/response handshake of the masked S-box sequencer.
interface masked_sbox_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [7:0]   in_mask;
    logic [7:0]   out_mask;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] o_data;

    modport master (
        output in_valid, in_data, in_mask, out_mask, o_ready,
        input  in_ready, o_valid, o_data
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_mask, o_ready,
        output in_ready, o_valid, o_data
    );
endinterface

// File: rtl/masked_sbox_seq.sv
// masked_sbox_seq: streams the 16 bytes of a masked state through one shared masked S-box
// of SBOX_LAT cycles latency and reassembles the substituted, re-masked state.
module masked_sbox_seq #(
    parameter int SBOX_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    masked_sbox_seq_if.slave io,
    output logic [7:0]       sb_x,
    output logic [7:0]       sb_m,
    output logic [7:0]       sb_n,
    input  logic [7:0]       sb_y,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [15:0][7:0] din;
    logic [15:0][7:0] res;
    logic [3:0]       issue_idx;
    logic [3:0]       cap_idx;
    logic             in_ready;
    logic             o_valid;
    logic             issuing;
    logic             tap;

    assign issuing     = state == ISSUE;
    assign io.in_ready = in_ready;
    assign io.o_valid  = o_valid;
    assign io.o_data   = res;

    // The tap marks the cycle in which sb_y belongs to the byte issued SBOX_LAT cycles earlier.
    if (SBOX_LAT == 0) begin : g_comb
        assign tap = issuing;
    end else begin : g_pipe
        logic [SBOX_LAT-1:0] vld;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) vld <= '0;
            else        vld <= (vld << 1) | SBOX_LAT'(issuing);
        assign tap = vld[SBOX_LAT-1];
    end

    // sb_m/sb_n double as the captured mask registers; they only carry values while issuing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            o_valid   <= 1'b0;
            busy      <= 1'b0;
            sb_x      <= '0;
            sb_m      <= '0;
            sb_n      <= '0;
            din       <= '0;
            res       <= '0;
            issue_idx <= '0;
            cap_idx   <= '0;
        end else begin
            if (tap) begin
                res[cap_idx] <= sb_y;
                cap_idx      <= cap_idx + 4'd1;
            end
            case (state)
                IDLE: if (io.in_valid) begin
                    state     <= ISSUE;
                    in_ready  <= 1'b0;
                    busy      <= 1'b1;
                    din       <= io.in_data;
                    sb_x      <= io.in_data[7:0];
                    sb_m      <= io.in_mask;
                    sb_n      <= io.out_mask;
                    issue_idx <= '0;
                    cap_idx   <= '0;
                end
                ISSUE: if (issue_idx == 4'd15) begin
                    state   <= SBOX_LAT == 0 ? DONE : DRAIN;
                    o_valid <= SBOX_LAT == 0;
                    sb_x    <= '0;
                    sb_m    <= '0;
                    sb_n    <= '0;
                end else begin
                    issue_idx <= issue_idx + 4'd1;
                    sb_x      <= din[issue_idx + 4'd1];
                end
                DRAIN: if (tap && cap_idx == 4'd15) begin
                    state   <= DONE;
                    o_valid <= 1'b1;
                end
                DONE: if (io.o_ready) begin
                    state    <= IDLE;
                    o_valid  <= 1'b0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_masked_sbox_seq.sv
// tb_masked_sbox_seq: four sequencers (SBOX_LAT 0..3) share one stimulus stream, each paired
// with an ideal masked S-box model; results are checked against a whole-state reference.
module tb_masked_sbox_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         o_ready;
    logic [127:0] in_data;
    logic [7:0]   in_mask;
    logic [7:0]   out_mask;

    logic [3:0]        rdy_l, ov_l, busy_l;
    logic [3:0][127:0] od_l;
    logic [3:0][7:0]   sbx_l, sbm_l, sbn_l;

    int vectors = 0;
    int errors  = 0;

    int           lat_seen [4];
    logic [127:0] od_seen  [4];
    logic [7:0]   trace    [4][24];

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic [7:0] mi, input logic [7:0] mo);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = aes_sbox(d[8*k +: 8] ^ mi) ^ mo;
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        masked_sbox_seq_if bus ();
        logic [7:0] x, m, n, y, f;
        logic       b;
        assign bus.in_valid = in_valid;
        assign bus.in_data  = in_data;
        assign bus.in_mask  = in_mask;
        assign bus.out_mask = out_mask;
        assign bus.o_ready  = o_ready;
        assign f = aes_sbox(x ^ m) ^ n;
        if (g == 0) begin : g_c
            assign y = f;
        end else begin : g_p
            logic [7:0] sr [g];
            always_ff @(posedge clk) begin
                sr[0] <= f;
                for (int i = 1; i < g; i++) sr[i] <= sr[i-1];
            end
            assign y = sr[g-1];
        end
        masked_sbox_seq #(.SBOX_LAT(g)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .io   (bus),
            .sb_x (x),
            .sb_m (m),
            .sb_n (n),
            .sb_y (y),
            .busy (b)
        );
        assign rdy_l[g]  = bus.in_ready;
        assign ov_l[g]   = bus.o_valid;
        assign od_l[g]   = bus.o_data;
        assign busy_l[g] = b;
        assign sbx_l[g]  = x;
        assign sbm_l[g]  = m;
        assign sbn_l[g]  = n;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers one block to all lanes at once and records latency, result and sb_x trace per lane.
    task automatic run_block(input logic [127:0] d, input logic [7:0] mi, input logic [7:0] mo);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = mi;
        out_mask = mo;
        o_ready  = 1'b1;
        tick;
        in_valid = 1'b0;
        in_data  = rand128();
        in_mask  = 8'($urandom);
        out_mask = 8'($urandom);
        for (int g = 0; g < 4; g++) lat_seen[g] = -1;
        for (int c = 0; c < 24; c++) begin
            for (int g = 0; g < 4; g++) begin
                trace[g][c] = sbx_l[g];
                if (ov_l[g] && lat_seen[g] < 0) begin
                    lat_seen[g] = c;
                    od_seen[g]  = od_l[g];
                end
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        o_ready  = 1'b0;
        in_data  = '0;
        in_mask  = '0;
        out_mask = '0;
        repeat (3) tick;
        for (int g = 0; g < 4; g++) begin
            vectors++;
            if ({rdy_l[g], ov_l[g], busy_l[g]} !== 3'b100 || sbx_l[g] !== 8'h00 || od_l[g] !== 128'h0) begin
                errors++;
                $display("FAIL reset_hold lane%0d: rdy/ov/busy=%b%b%b sb_x=%h o_data=%h, want 100 00 0",
                         g, rdy_l[g], ov_l[g], busy_l[g], sbx_l[g], od_l[g]);
            end
        end
        rst_n = 1'b1;
        tick;
        for (int g = 0; g < 4; g++) begin
            vectors++;
            if ({rdy_l[g], ov_l[g], busy_l[g]} !== 3'b100 || sbx_l[g] !== 8'h00) begin
                errors++;
                $display("FAIL idle lane%0d: rdy/ov/busy=%b%b%b sb_x=%h, want 100 00",
                         g, rdy_l[g], ov_l[g], busy_l[g], sbx_l[g]);
            end
        end
    endtask

    task automatic test_single;
        logic [127:0] st = 128'h00112233445566778899aabbccddeeff;
        run_block(st ^ {16{8'h5a}}, 8'h5a, 8'hc3);
        vectors++;
        if (lat_seen[1] != 17) begin
            errors++;
            $display("FAIL fips_latency: got %0d cycles, want 17", lat_seen[1]);
        end
        vectors++;
        if ((od_seen[1] ^ {16{8'hc3}}) !== 128'h638293c31bfc33f5c4eeacea4bc12816) begin
            errors++;
            $display("FAIL fips_data: unmasked o_data=%h, want 638293c31bfc33f5c4eeacea4bc12816",
                     od_seen[1] ^ {16{8'hc3}});
        end
    endtask

    task automatic test_sweep;
        for (int r = 0; r < 3; r++) begin
            logic [127:0] d = rand128();
            logic [7:0]   mi = 8'($urandom);
            logic [7:0]   mo = 8'($urandom);
            logic [127:0] exp_d = ref_sub(d, mi, mo);
            run_block(d, mi, mo);
            for (int g = 0; g < 4; g++) begin
                logic [127:0] seq;
                for (int k = 0; k < 16; k++) seq[8*k +: 8] = trace[g][k];
                vectors++;
                if (lat_seen[g] != 16 + g) begin
                    errors++;
                    $display("FAIL sweep_latency lane%0d: got %0d, want %0d", g, lat_seen[g], 16 + g);
                end
                vectors++;
                if (od_seen[g] !== exp_d) begin
                    errors++;
                    $display("FAIL sweep_data lane%0d: got %h, want %h", g, od_seen[g], exp_d);
                end
                vectors++;
                if (seq !== d || trace[g][16] !== 8'h00) begin
                    errors++;
                    $display("FAIL sweep_sbx_order lane%0d: got %h then %h, want %h then 00",
                             g, seq, trace[g][16], d);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] d = rand128();
        logic [7:0]   mi = 8'($urandom);
        logic [7:0]   mo = 8'($urandom);
        logic [127:0] exp_d = ref_sub(d, mi, mo);
        logic [3:0][127:0] hold;
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = mi;
        out_mask = mo;
        o_ready  = 1'b0;
        tick;
        in_valid = 1'b0;
        in_data  = rand128();
        while (ov_l !== 4'hf && w < 40) begin
            tick;
            w++;
        end
        vectors++;
        if (ov_l !== 4'hf) begin
            errors++;
            $display("FAIL bp_done_timeout: o_valid=%b, want 1111", ov_l);
        end
        hold = od_l;
        for (int g = 0; g < 4; g++) begin
            vectors++;
            if (hold[g] !== exp_d) begin
                errors++;
                $display("FAIL bp_data lane%0d: got %h, want %h", g, hold[g], exp_d);
            end
        end
        repeat (10) begin
            tick;
            for (int g = 0; g < 4; g++) begin
                vectors++;
                if ({od_l[g], sbx_l[g], sbm_l[g], sbn_l[g], rdy_l[g], ov_l[g], busy_l[g]} !==
                    {hold[g], 24'h0, 3'b011}) begin
                    errors++;
                    $display("FAIL bp_stall lane%0d: o_data=%h sb=%h%h%h rdy/ov/busy=%b%b%b, want %h 000000 011",
                             g, od_l[g], sbx_l[g], sbm_l[g], sbn_l[g], rdy_l[g], ov_l[g], busy_l[g], hold[g]);
                end
            end
        end
        o_ready = 1'b1;
        tick;
        for (int g = 0; g < 4; g++) begin
            vectors++;
            if ({rdy_l[g], ov_l[g], busy_l[g]} !== 3'b100) begin
                errors++;
                $display("FAIL bp_release lane%0d: rdy/ov/busy=%b%b%b, want 100", g, rdy_l[g], ov_l[g], busy_l[g]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] d = rand128();
        logic [127:0] d2 = rand128();
        logic [7:0]   mi = 8'($urandom);
        logic [7:0]   mo = 8'($urandom);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = mi;
        out_mask = mo;
        o_ready  = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (7) tick;
        vectors++;
        if (sbx_l[1] !== d[8*7 +: 8]) begin
            errors++;
            $display("FAIL mid_position: sb_x=%h, want byte7 %h", sbx_l[1], d[8*7 +: 8]);
        end
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            vectors++;
            if ({rdy_l[g], ov_l[g], busy_l[g]} !== 3'b100 || {sbx_l[g], sbm_l[g], sbn_l[g]} !== 24'h0 ||
                od_l[g] !== 128'h0) begin
                errors++;
                $display("FAIL mid_reset lane%0d: rdy/ov/busy=%b%b%b sb=%h%h%h o_data=%h, want 100 000000 0",
                         g, rdy_l[g], ov_l[g], busy_l[g], sbx_l[g], sbm_l[g], sbn_l[g], od_l[g]);
            end
        end
        tick;
        rst_n = 1'b1;
        tick;
        mi = 8'($urandom);
        mo = 8'($urandom);
        run_block(d2, mi, mo);
        for (int g = 0; g < 4; g++) begin
            vectors++;
            if (lat_seen[g] != 16 + g || od_seen[g] !== ref_sub(d2, mi, mo)) begin
                errors++;
                $display("FAIL mid_recover lane%0d: lat %0d data %h, want lat %0d data %h",
                         g, lat_seen[g], od_seen[g], 16 + g, ref_sub(d2, mi, mo));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] d1 = rand128();
        logic [127:0] d2 = rand128();
        logic [7:0]   mi = 8'($urandom);
        logic [7:0]   mo = 8'($urandom);
        int           hs [4];
        int           h1 [4];
        int           a2 [4];
        logic [127:0] od1 [4];
        logic [127:0] od2 [4];
        for (int g = 0; g < 4; g++) begin
            hs[g] = 0;
            h1[g] = -1;
            a2[g] = -1;
            od1[g] = '0;
            od2[g] = '0;
        end
        in_valid = 1'b1;
        in_data  = d1;
        in_mask  = mi;
        out_mask = mo;
        o_ready  = 1'b1;
        tick;
        in_data = d2;
        for (int c = 0; c < 45; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (ov_l[g]) begin
                    if (hs[g] == 0) begin
                        h1[g]  = c + 1;
                        od1[g] = od_l[g];
                    end else if (hs[g] == 1) od2[g] = od_l[g];
                    hs[g]++;
                end
                if (rdy_l[g] && a2[g] < 0) a2[g] = c + 1;
            end
            tick;
        end
        in_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            vectors++;
            if (h1[g] != 17 + g || a2[g] != h1[g] + 1) begin
                errors++;
                $display("FAIL b2b_timing lane%0d: handshake edge %0d accept edge %0d, want %0d and %0d",
                         g, h1[g], a2[g], 17 + g, 18 + g);
            end
            vectors++;
            if (hs[g] < 2 || od1[g] !== ref_sub(d1, mi, mo) || od2[g] !== ref_sub(d2, mi, mo)) begin
                errors++;
                $display("FAIL b2b_data lane%0d: %0d results, got %h %h, want %h %h",
                         g, hs[g], od1[g], od2[g], ref_sub(d1, mi, mo), ref_sub(d2, mi, mo));
            end
        end
        repeat (25) tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_sweep;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
